exc_commit_ctrl: RTL and testbench

EXC_COMMIT_CTRL -- requirements
Module: exc_commit_ctrl

---
 rtl/exc_pkg.sv | 34 +++
 rtl/exc_prio_enc.sv | 41 ++++
 rtl/exc_commit_ctrl.sv | 163 ++++++++++++++++
 tb/tb_exc_commit_ctrl.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/exc_pkg.sv
// Shared definitions for the exception/commit controller: ExcCode values,
// cm_exc flag bit positions, FSM state encoding and the EPC helper.
package exc_pkg;

  localparam int unsigned EXC_W       = 7;
  localparam int unsigned BIT_ADEL_IF = 0;
  localparam int unsigned BIT_RI      = 1;
  localparam int unsigned BIT_OV      = 2;
  localparam int unsigned BIT_SYS     = 3;
  localparam int unsigned BIT_BP      = 4;
  localparam int unsigned BIT_ADEL_D  = 5;
  localparam int unsigned BIT_ADES_D  = 6;

  localparam logic [4:0] CODE_INT  = 5'd0;
  localparam logic [4:0] CODE_ADEL = 5'd4;
  localparam logic [4:0] CODE_ADES = 5'd5;
  localparam logic [4:0] CODE_SYS  = 5'd8;
  localparam logic [4:0] CODE_BP   = 5'd9;
  localparam logic [4:0] CODE_RI   = 5'd10;
  localparam logic [4:0] CODE_OV   = 5'd12;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    EXC   = 2'd1,
    ERET  = 2'd2,
    REDIR = 2'd3
  } exc_state_e;

  // A delay-slot instruction reports the address of its branch as EPC.
  function automatic logic [31:0] epc_of(input logic [31:0] pc, input logic bd);
    epc_of = bd ? (pc - 32'd4) : pc;
  endfunction

endpackage

// File: rtl/exc_prio_enc.sv
// Fixed-priority exception selector: picks exactly one winning cause from
// the interrupt request and the commit-stage flags.
module exc_prio_enc
  import exc_pkg::*;
(
  input  logic             i_int,
  input  logic [EXC_W-1:0] i_flags,
  output logic             o_valid,
  output logic [4:0]       o_code,
  output logic             o_is_data
);

  // Priority chain; fetch-side faults outrank execute-side, data faults last.
  always_comb begin
    o_valid   = 1'b1;
    o_code    = CODE_INT;
    o_is_data = 1'b0;
    if (i_int) begin
      o_code = CODE_INT;
    end else if (i_flags[BIT_ADEL_IF]) begin
      o_code = CODE_ADEL;
    end else if (i_flags[BIT_RI]) begin
      o_code = CODE_RI;
    end else if (i_flags[BIT_OV]) begin
      o_code = CODE_OV;
    end else if (i_flags[BIT_SYS]) begin
      o_code = CODE_SYS;
    end else if (i_flags[BIT_BP]) begin
      o_code = CODE_BP;
    end else if (i_flags[BIT_ADEL_D]) begin
      o_code    = CODE_ADEL;
      o_is_data = 1'b1;
    end else if (i_flags[BIT_ADES_D]) begin
      o_code    = CODE_ADES;
      o_is_data = 1'b1;
    end else begin
      o_valid = 1'b0;
    end
  end

endmodule

// File: rtl/exc_commit_ctrl.sv
// Commit-point exception/ERET controller: records the exception for CP0,
// flushes younger stages and holds a fetch redirect until accepted.
// Interrupt handling is compiled in only when EXC_INT_EN is defined.
module exc_commit_ctrl
  import exc_pkg::*;
#(
  parameter logic [31:0] EXC_VECTOR = 32'hBFC0_0380
)(
  input  logic             clk,
  input  logic             rstn,
  input  logic             cm_valid,
  input  logic [31:0]      cm_pc,
  input  logic             cm_bd,
  input  logic [EXC_W-1:0] cm_exc,
  input  logic [31:0]      cm_badvaddr,
  input  logic             cm_eret,
  input  logic             int_req,
  input  logic             status_exl,
  input  logic [31:0]      return_addr,
  output logic             exc_valid,
  output logic [4:0]       exc_code,
  output logic [31:0]      exc_epc,
  output logic             exc_bd,
  output logic [31:0]      exc_badvaddr,
  output logic             eret_clr,
  output logic             commit_ok,
  output logic             flush,
  output logic             redir_valid,
  output logic [31:0]      redir_pc,
  input  logic             redir_ready
);

  exc_state_e  r_state;
  exc_state_e  w_state_nxt;
  logic        w_int;
  logic        w_prio_valid;
  logic [4:0]  w_prio_code;
  logic        w_prio_is_data;
  logic        w_idle;
  logic        w_take_exc;
  logic        w_take_eret;
  logic        w_fetch_adel;

  logic        r_exc_valid;
  logic        r_eret_clr;
  logic        r_flush;
  logic        r_redir_valid;
  logic [4:0]  r_exc_code;
  logic [31:0] r_exc_epc;
  logic        r_exc_bd;
  logic [31:0] r_exc_badvaddr;
  logic [31:0] r_redir_pc;

`ifdef EXC_INT_EN
  assign w_int = int_req & ~status_exl;
`else
  logic w_unused_int;
  assign w_unused_int = int_req ^ status_exl;
  assign w_int        = 1'b0;
`endif

  exc_prio_enc u_prio (
    .i_int     (w_int),
    .i_flags   (cm_exc),
    .o_valid   (w_prio_valid),
    .o_code    (w_prio_code),
    .o_is_data (w_prio_is_data)
  );

  assign w_idle       = (r_state == IDLE);
  assign w_take_exc   = w_idle & cm_valid & w_prio_valid;
  assign w_take_eret  = w_idle & cm_valid & cm_eret & ~w_prio_valid;
  assign w_fetch_adel = (w_prio_code == CODE_ADEL) & ~w_prio_is_data;
  assign commit_ok    = cm_valid & w_idle & ~w_take_exc & ~cm_eret;

  // State register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic; exceptions beat ERET on the same instruction.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: begin
        if (w_take_exc) begin
          w_state_nxt = EXC;
        end else if (w_take_eret) begin
          w_state_nxt = ERET;
        end else begin
          w_state_nxt = IDLE;
        end
      end
      EXC:   w_state_nxt = REDIR;
      ERET:  w_state_nxt = REDIR;
      REDIR: begin
        if (redir_ready) begin
          w_state_nxt = IDLE;
        end else begin
          w_state_nxt = REDIR;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Control strobes registered from the next state so they align with it.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_exc_valid   <= 1'b0;
      r_eret_clr    <= 1'b0;
      r_flush       <= 1'b0;
      r_redir_valid <= 1'b0;
    end else begin
      r_exc_valid   <= (w_state_nxt == EXC);
      r_eret_clr    <= (w_state_nxt == ERET);
      r_flush       <= (w_state_nxt != IDLE);
      r_redir_valid <= (w_state_nxt == REDIR);
    end
  end

  // Exception record and redirect target, captured only in the taking cycle.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_exc_code     <= 5'd0;
      r_exc_epc      <= 32'd0;
      r_exc_bd       <= 1'b0;
      r_exc_badvaddr <= 32'd0;
      r_redir_pc     <= 32'd0;
    end else if (w_take_exc) begin
      r_exc_code <= w_prio_code;
      r_exc_epc  <= epc_of(cm_pc, cm_bd);
      r_exc_bd   <= cm_bd;
      r_redir_pc <= EXC_VECTOR;
      if (w_prio_is_data) begin
        r_exc_badvaddr <= cm_badvaddr;
      end else if (w_fetch_adel) begin
        r_exc_badvaddr <= cm_pc;
      end else begin
        r_exc_badvaddr <= r_exc_badvaddr;
      end
    end else if (w_take_eret) begin
      r_redir_pc <= return_addr;
    end else begin
      r_redir_pc <= r_redir_pc;
    end
  end

  assign exc_valid    = r_exc_valid;
  assign eret_clr     = r_eret_clr;
  assign flush        = r_flush;
  assign redir_valid  = r_redir_valid;
  assign exc_code     = r_exc_code;
  assign exc_epc      = r_exc_epc;
  assign exc_bd       = r_exc_bd;
  assign exc_badvaddr = r_exc_badvaddr;
  assign redir_pc     = r_redir_pc;

endmodule

// File: tb/tb_exc_commit_ctrl.sv
// Randomized self-checking bench for exc_commit_ctrl against a transaction-level
// reference model; honours EXC_INT_EN the same way as the design build.
module tb_exc_commit_ctrl;

  localparam logic [31:0] VEC = 32'hBFC0_0380;

  logic        clk = 1'b0;
  logic        rstn;
  logic        cm_valid;
  logic [31:0] cm_pc;
  logic        cm_bd;
  logic [6:0]  cm_exc;
  logic [31:0] cm_badvaddr;
  logic        cm_eret;
  logic        int_req;
  logic        status_exl;
  logic [31:0] return_addr;
  logic        exc_valid;
  logic [4:0]  exc_code;
  logic [31:0] exc_epc;
  logic        exc_bd;
  logic [31:0] exc_badvaddr;
  logic        eret_clr;
  logic        commit_ok;
  logic        flush;
  logic        redir_valid;
  logic [31:0] redir_pc;
  logic        redir_ready;

  int n_cmp = 0;
  int n_err = 0;

  // Model state that persists across transactions.
  logic [31:0] m_badv;

  always #5 clk = ~clk;

  exc_commit_ctrl #(.EXC_VECTOR(VEC)) dut (
    .clk(clk), .rstn(rstn), .cm_valid(cm_valid), .cm_pc(cm_pc), .cm_bd(cm_bd),
    .cm_exc(cm_exc), .cm_badvaddr(cm_badvaddr), .cm_eret(cm_eret),
    .int_req(int_req), .status_exl(status_exl), .return_addr(return_addr),
    .exc_valid(exc_valid), .exc_code(exc_code), .exc_epc(exc_epc), .exc_bd(exc_bd),
    .exc_badvaddr(exc_badvaddr), .eret_clr(eret_clr), .commit_ok(commit_ok),
    .flush(flush), .redir_valid(redir_valid), .redir_pc(redir_pc),
    .redir_ready(redir_ready)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h @%0t", tag, got, exp, $time);
    end
  endtask

  // Junk on the commit inputs while the controller is busy; must be ignored.
  task automatic scramble_inputs();
    logic [31:0] r;
    r = $urandom;
    cm_valid    = 1'b1;
    cm_pc       = $urandom;
    cm_bd       = r[0];
    cm_exc      = r[7:1];
    cm_badvaddr = $urandom;
    cm_eret     = r[8];
    int_req     = r[9];
    status_exl  = r[10];
    return_addr = $urandom;
  endtask

  // One commit transaction, entered and left just after a falling edge.
  task automatic do_commit(input logic v, input logic [31:0] pc, input logic bd,
                           input logic [6:0] ex, input logic [31:0] badv,
                           input logic er, input logic ir, input logic exl,
                           input logic [31:0] ra, input int stall);
    logic [4:0]  code_tab [7];
    logic        mi;
    logic        take_exc;
    logic        take_eret;
    logic        found;
    logic [4:0]  m_code;
    logic [31:0] m_redir;
    logic [31:0] m_epc;
    code_tab = '{5'd4, 5'd10, 5'd12, 5'd8, 5'd9, 5'd4, 5'd5};

    cm_valid = v; cm_pc = pc; cm_bd = bd; cm_exc = ex; cm_badvaddr = badv;
    cm_eret = er; int_req = ir; status_exl = exl; return_addr = ra;
    redir_ready = 1'b0;

    mi = 1'b0;
`ifdef EXC_INT_EN
    mi = ir && !exl;
`endif
    take_exc  = v && (mi || (ex != 7'd0));
    take_eret = v && er && !take_exc;
    m_code    = 5'd0;
    if (take_exc && !mi) begin
      found = 1'b0;
      for (int i = 0; i < 7; i++) begin
        if (!found && ex[i]) begin
          found  = 1'b1;
          m_code = code_tab[i];
          if (i == 0) m_badv = pc;
          else if (i >= 5) m_badv = badv;
        end
      end
    end
    m_epc   = bd ? pc - 32'd4 : pc;
    m_redir = take_exc ? VEC : ra;

    #1;
    check_eq("commit_ok", 32'(commit_ok), 32'(v && !take_exc && !er));
    @(negedge clk);
    scramble_inputs();
    redir_ready = $urandom_range(0, 1) == 1;
    #1;
    if (!take_exc && !take_eret) begin
      check_eq("idle_exc_valid", 32'(exc_valid), 32'd0);
      check_eq("idle_flush", 32'(flush), 32'd0);
      check_eq("idle_eret_clr", 32'(eret_clr), 32'd0);
      check_eq("idle_redir_valid", 32'(redir_valid), 32'd0);
      cm_valid = 1'b0;
      return;
    end
    check_eq("exc_valid", 32'(exc_valid), 32'(take_exc));
    check_eq("eret_clr", 32'(eret_clr), 32'(take_eret));
    check_eq("flush_1st", 32'(flush), 32'd1);
    check_eq("redir_valid_1st", 32'(redir_valid), 32'd0);
    check_eq("busy_commit_ok", 32'(commit_ok), 32'd0);
    if (take_exc) begin
      check_eq("exc_code", 32'(exc_code), 32'(m_code));
      check_eq("exc_epc", exc_epc, m_epc);
      check_eq("exc_bd", 32'(exc_bd), 32'(bd));
      check_eq("exc_badvaddr", exc_badvaddr, m_badv);
    end
    @(negedge clk);
    for (int k = 0; k <= stall; k++) begin
      #1;
      check_eq("redir_valid", 32'(redir_valid), 32'd1);
      check_eq("redir_flush", 32'(flush), 32'd1);
      check_eq("redir_pc", redir_pc, m_redir);
      check_eq("redir_exc_valid", 32'(exc_valid), 32'd0);
      check_eq("redir_eret_clr", 32'(eret_clr), 32'd0);
      scramble_inputs();
      redir_ready = (k == stall);
      @(negedge clk);
    end
    cm_valid = 1'b0;
    redir_ready = 1'b0;
    #1;
    check_eq("back_redir_valid", 32'(redir_valid), 32'd0);
    check_eq("back_flush", 32'(flush), 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] r;
    rstn = 1'b0; m_badv = 32'd0;
    cm_valid = 1'b0; cm_pc = 32'd0; cm_bd = 1'b0; cm_exc = 7'd0; cm_badvaddr = 32'd0;
    cm_eret = 1'b0; int_req = 1'b0; status_exl = 1'b0; return_addr = 32'd0;
    redir_ready = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("rst_exc_valid", 32'(exc_valid), 32'd0);
    check_eq("rst_flush", 32'(flush), 32'd0);
    check_eq("rst_redir_valid", 32'(redir_valid), 32'd0);
    check_eq("rst_redir_pc", redir_pc, 32'd0);
    check_eq("rst_exc_epc", exc_epc, 32'd0);
    rstn = 1'b1;
    @(negedge clk);

    // Directed cases.
    do_commit(1'b1, 32'h100, 1'b0, 7'b0000100, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 0);
    do_commit(1'b1, 32'h204, 1'b1, 7'b0001010, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 0);
    do_commit(1'b1, 32'h300, 1'b0, 7'b1000000, 32'h1003, 1'b0, 1'b0, 1'b0, 32'h0, 5);
    do_commit(1'b1, 32'h500, 1'b0, 7'b0010000, 32'hDEAD, 1'b0, 1'b0, 1'b0, 32'h0, 1);
    do_commit(1'b1, 32'h600, 1'b0, 7'b0000000, 32'h0, 1'b1, 1'b0, 1'b0, 32'h400, 0);
    do_commit(1'b1, 32'h604, 1'b0, 7'b0000000, 32'h0, 1'b1, 1'b1, 1'b0, 32'h440, 0);
    do_commit(1'b1, 32'h608, 1'b0, 7'b0000000, 32'h0, 1'b1, 1'b1, 1'b1, 32'h480, 2);
    do_commit(1'b1, 32'h0, 1'b1, 7'b0000001, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 0);
    do_commit(1'b0, 32'h700, 1'b0, 7'b1111111, 32'h0, 1'b1, 1'b1, 1'b0, 32'h0, 0);
    do_commit(1'b1, 32'h704, 1'b0, 7'b0000000, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 0);

    // Asynchronous reset while holding a redirect.
    cm_valid = 1'b1; cm_pc = 32'h800; cm_bd = 1'b0; cm_exc = 7'b0000100; cm_eret = 1'b0;
    int_req = 1'b0; redir_ready = 1'b0;
    @(negedge clk);
    cm_valid = 1'b0;
    @(negedge clk);
    #1;
    check_eq("pre_rst_redir_valid", 32'(redir_valid), 32'd1);
    #2;
    rstn = 1'b0;
    #1;
    check_eq("async_flush", 32'(flush), 32'd0);
    check_eq("async_redir_valid", 32'(redir_valid), 32'd0);
    check_eq("async_exc_valid", 32'(exc_valid), 32'd0);
    check_eq("async_redir_pc", redir_pc, 32'd0);
    check_eq("async_exc_code", 32'(exc_code), 32'd0);
    m_badv = 32'd0;
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    #1;
    check_eq("post_rst_flush", 32'(flush), 32'd0);
    check_eq("post_rst_redir_valid", 32'(redir_valid), 32'd0);
    do_commit(1'b1, 32'h900, 1'b0, 7'b0000000, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 0);

    // Randomized transactions.
    for (int t = 0; t < 400; t++) begin
      logic [6:0] ex;
      r = $urandom;
      case (r[1:0])
        2'd0: ex = 7'd0;
        2'd1: ex = 7'd1 << $urandom_range(0, 6);
        default: ex = r[8:2];
      endcase
      do_commit(r[12:9] != 4'd0, $urandom, r[13], ex, $urandom, r[15:14] == 2'd0,
                r[16], r[17], $urandom, $urandom_range(0, 3));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
